// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin-charger control slice.
// One-hot states, BCD digit type and BCD/binary conversion.
package coin_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_INPUT  = 4'b0010,
      S_CHARGE = 4'b0100,
      S_DONE   = 4'b1000
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t KEY_MAX = 4'd9;

   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      bcd_t t;
      bcd_t u;
      t = 4'(v / 7'd10);
      u = 4'(v % 7'd10);
      return {t, u};
   endfunction

   function automatic logic [6:0] bcd2bin(input bcd_t tens,
                                          input bcd_t units);
      return 7'(tens) * 7'd10 + 7'(units);
   endfunction

endpackage

// File: rtl/charge_ctrl_if.sv
// Key strobes in from the scanner, display/switch values out.
// master = scanner/display side, slave = charge_ctrl.
interface charge_ctrl_if;
   import coin_pkg::*;

   bcd_t       key_data;
   logic       key_digit;
   logic       key_start;
   logic       key_ok;
   logic       key_reset;
   logic [7:0] amt_bcd;
   logic [7:0] time_bcd;
   logic       charging;
   logic       done;
   logic [3:0] state_view;

   modport master (
      output key_data, key_digit, key_start,
      output key_ok, key_reset,
      input  amt_bcd, time_bcd, charging,
      input  done, state_view
   );

   modport slave (
      input  key_data, key_digit, key_start,
      input  key_ok, key_reset,
      output amt_bcd, time_bcd, charging,
      output done, state_view
   );

endinterface

// File: rtl/charge_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles after clr.
// tick is combinational so the consuming edge lands exactly TICK_DIV after clr.
module tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [W-1:0] cnt_q;
   logic         last;

   assign last = (cnt_q == W'(TICK_DIV - 1));
   assign tick = en && !clr && last;

   always_ff @(posedge clk) begin
      if (clr)
         cnt_q <= '0;
      else if (en)
         cnt_q <= last ? '0 : cnt_q + W'(1);
   end

endmodule

// File: rtl/charge_ctrl.sv
// Coin-charger control: amount entry, confirm, per-second countdown.
// Amount kept in BCD, remaining time in binary.
module charge_ctrl
   import coin_pkg::*;
#(
   parameter int TICK_DIV      = 100000,
   parameter int TIME_PER_UNIT = 2,
   parameter int MAX_AMOUNT    = 20,
   parameter int IDLE_TIMEOUT  = 10
) (
   input logic         CLK,
   input logic         rst,
   charge_ctrl_if.slave bus
);

   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [7:0] MAX_BCD = bin2bcd(7'(MAX_AMOUNT));

   state_t      state_q, state_d;
   bcd_t        tens_q, tens_d;
   bcd_t        units_q, units_d;
   logic [6:0]  time_q, time_d;
   logic [TW-1:0] to_q, to_d;
   logic [7:0]  time_bcd_q;
   logic        charging_q;
   logic        done_q;

   logic act_reset, act_start, act_ok, act_digit, any_key;
   logic tick, pre_clr, pre_en;
   logic [6:0] amt_bin, new_bin;

   // Only the highest-priority strobe is allowed to act.
   assign act_reset = bus.key_reset;
   assign act_start = bus.key_start & ~act_reset;
   assign act_ok    = bus.key_ok & ~bus.key_start & ~act_reset;
   assign act_digit = bus.key_digit & ~bus.key_ok
                      & ~bus.key_start & ~act_reset;
   assign any_key   = bus.key_reset | bus.key_start
                      | bus.key_ok | bus.key_digit;

   assign amt_bin = bcd2bin(tens_q, units_q);
   assign new_bin = bcd2bin(units_q, bus.key_data);

   assign pre_en  = (state_q == S_INPUT) || (state_q == S_CHARGE);
   assign pre_clr = rst || !pre_en
                    || ((state_q == S_INPUT) && any_key);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (CLK),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      units_d = units_q;
      time_d  = time_q;
      to_d    = to_q;
      unique case (state_q)
         S_IDLE: begin
            if (act_start) begin
               state_d = S_INPUT;
               tens_d  = '0;
               units_d = '0;
               to_d    = '0;
            end
         end
         S_INPUT: begin
            unique case (1'b1)
               act_reset: begin
                  state_d = S_IDLE;
                  tens_d  = '0;
                  units_d = '0;
               end
               act_start: begin
                  tens_d  = '0;
                  units_d = '0;
               end
               act_ok: begin
                  if (amt_bin != '0) begin
                     state_d = S_CHARGE;
                     time_d  = 7'(amt_bin * 7'(TIME_PER_UNIT));
                  end
               end
               act_digit: begin
                  if (bus.key_data <= KEY_MAX && tens_q == '0) begin
                     if (new_bin > 7'(MAX_AMOUNT)) begin
                        tens_d  = MAX_BCD[7:4];
                        units_d = MAX_BCD[3:0];
                     end else begin
                        tens_d  = units_q;
                        units_d = bus.key_data;
                     end
                  end
               end
               default: begin
                  if (tick) begin
                     if (to_q == TW'(IDLE_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        tens_d  = '0;
                        units_d = '0;
                     end else begin
                        to_d = to_q + TW'(1);
                     end
                  end
               end
            endcase
            if (any_key)
               to_d = '0;
         end
         S_CHARGE: begin
            if (act_reset) begin
               state_d = S_IDLE;
               tens_d  = '0;
               units_d = '0;
               time_d  = '0;
            end else if (tick) begin
               time_d = time_q - 7'd1;
               if (time_q == 7'd1)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            tens_d  = '0;
            units_d = '0;
            time_d  = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tens_q     <= '0;
         units_q    <= '0;
         time_q     <= '0;
         to_q       <= '0;
         time_bcd_q <= '0;
         charging_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tens_q     <= tens_d;
         units_q    <= units_d;
         time_q     <= time_d;
         to_q       <= to_d;
         time_bcd_q <= bin2bcd(time_d);
         charging_q <= (state_d == S_CHARGE);
         done_q     <= (state_d == S_DONE);
      end
   end

   assign bus.amt_bcd    = {tens_q, units_q};
   assign bus.time_bcd   = time_bcd_q;
   assign bus.charging   = charging_q;
   assign bus.done       = done_q;
   assign bus.state_view = state_q;

endmodule

// File: doc/charge_ctrl.md
# charge_ctrl

Coin-charger control stage, directly downstream of the keypad scanner. Consumes the scanner's decoded one-cycle key strobes, accumulates a two-digit charge amount, and on confirmation runs a per-second countdown of charging time. Drives BCD amount/time values to the display stage and a `charging` enable to the output switch.

## Interface
Parameters:
- `TICK_DIV`, 100000: CLK cycles per 1 s tick. Default is 1 s at the 100 kHz system clock.
- `TIME_PER_UNIT`, 2: seconds of charge per unit of amount.
- `MAX_AMOUNT`, 20: amount ceiling. `MAX_AMOUNT*TIME_PER_UNIT` must be ≤ 99.
- `IDLE_TIMEOUT`, 10: ticks with no key in INPUT before returning to IDLE.

Ports:
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_data` in 4: key code, valid only with `key_digit`.
- `key_digit` in 1: one-cycle strobe, digit key pressed.
- `key_start` in 1: one-cycle strobe, start key.
- `key_ok` in 1: one-cycle strobe, confirm key.
- `key_reset` in 1: one-cycle strobe, cancel key.
- `amt_bcd` out 8: amount, {tens, units} BCD.
- `time_bcd` out 8: remaining seconds, {tens, units} BCD.
- `charging` out 1: high while in CHARGE.
- `done` out 1: one-cycle pulse on natural countdown completion.
- `state_view` out 4: one-hot state, for the bench and debug.

## Operation
States are one-hot: IDLE=0001, INPUT=0010, CHARGE=0100, DONE=1000.

Reset (`rst`=1 at an edge):
- State goes to IDLE.
- `amt_bcd`, `time_bcd`, `charging`, `done` all go to 0.
- Prescaler and timeout counters clear.

Strobe priority when several strobes are high in the same cycle: `key_reset` > `key_start` > `key_ok` > `key_digit`. Only the highest-priority strobe acts.

State behaviour:
- **IDLE**: `key_start` → INPUT with amount 00. All other strobes are ignored.
- **INPUT**, handling of `key_digit`:
  - `key_data` > 9: ignored.
  - If amount tens = 0, the new amount is {units, `key_data`}. This shifts the digit in.
  - If tens ≠ 0 (two digits already entered), the digit is ignored.
  - If the resulting binary value > `MAX_AMOUNT`, the amount is set to `MAX_AMOUNT` (clamp).
- **INPUT**, other strobes:
  - `key_ok` with amount 0: ignored.
  - `key_ok` with amount > 0: go to CHARGE and load time = amount × `TIME_PER_UNIT`.
  - `key_start`: clears the amount to 00 and stays in INPUT.
  - `key_reset`: IDLE, amount cleared.
  - `IDLE_TIMEOUT` consecutive ticks with no strobe: IDLE, amount cleared.
- **CHARGE**:
  - `charging`=1. Each tick decrements time.
  - On the tick where time goes 1→0: go to DONE.
  - `key_reset`: abort to IDLE. Time and amount are cleared, no `done` pulse.
  - `key_start`, `key_ok`, `key_digit` are ignored.
- **DONE**: lasts one cycle with `done`=1 and `charging`=0, then IDLE with amount cleared.

Arithmetic:
- Time is held in a 7-bit binary register and converted to BCD for `time_bcd`.
- The amount is held as BCD and converted to binary (tens×10+units) for the clamp comparison and the time load.

## Timing
- All outputs are registered. A strobe sampled at edge n shows its effect after edge n.
- Digit entry: `amt_bcd` is updated the cycle after `key_digit`.
- `key_ok` at edge n:
  - `charging`=1 and `time_bcd` loaded after edge n.
  - The prescaler restarts at the same edge.
  - First decrement happens `TICK_DIV` cycles later, so the first second is a full second.
- INPUT timeout: the prescaler restarts on entry to INPUT and on every strobe. The timeout counter counts ticks since the last strobe.
- Completion: DONE is entered at the tick edge where time reaches 0. `done` is high for exactly one cycle, `charging` drops at that same edge, and IDLE follows on the next edge.
- `rst` mid-CHARGE: next edge gives IDLE with all outputs 0. No `done` pulse.
- No strobe or `rst` activity: the state holds indefinitely, apart from the countdown and the timeout.

## Structure
- Shared package `coin_pkg`:
  - State encodings IDLE/INPUT/CHARGE/DONE.
  - BCD digit type.
  - Key code range constant (digits 0–9).
- Sub-module `tick_gen`:
  - Parameterised by `TICK_DIV`.
  - Inputs `clr` and `en`; output `tick`, a one-cycle pulse every `TICK_DIV` cycles after `clr`.
  - One instance, shared by the countdown and the timeout.
- Binary-to-BCD conversion for 0–99 is a combinational function in `coin_pkg`.

## Test plan
Bench runs with `TICK_DIV`=4 and defaults otherwise.
- **Basic charge**: start, digit 5, ok → `amt_bcd`=0x05 and `time_bcd`=0x10. `time_bcd` decrements every 4 cycles to 0x00, then `done` pulses once, `charging` falls, and state returns to IDLE.
- **Clamp and ignore**: start, digits 2, 7, 3 → `amt_bcd`=0x20 after the second digit. The third digit is ignored. `key_data`=12 with `key_digit` changes nothing.
- **Guard and priority**: ok with amount 00 → stays in INPUT. `key_reset` and `key_ok` in the same cycle → IDLE.
- **Abort**: `key_reset` in CHARGE at `time_bcd`=0x07 → IDLE next cycle, all outputs 0, no `done` pulse.
- **Timeout**: start then no keys for 40 cycles → IDLE at tick 10. A digit at tick 9 restarts the count.
- **Reset mid-operation**: `rst` asserted mid-CHARGE → IDLE, outputs 0. Start keys during CHARGE have no effect.
